// File: rtl/seg_capture.sv
// rtl/seg_capture.sv - seven-segment strobe capture with glitch rejection and staleness timeout
module seg_capture #(
  parameter int STABLE  = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] dig,
  input  logic [7:0] seg,
  output logic [3:0] num0,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [2:0] valid,
  output logic       upd,
  output logic       err
);

  localparam logic [7:0]  STB = 8'(STABLE);
  localparam logic [23:0] TO  = 24'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  dig_s1, dig_s2;
  logic [7:0]  seg_s1, seg_s2;
  logic [2:0]  ref_dig;
  logic [7:0]  ref_seg;
  logic [7:0]  cnt;
  logic [3:0]  num_r [3];
  logic [23:0] refresh [3];

  logic        dig_onehot;
  logic        same_as_ref;
  logic        cap_now;
  logic [4:0]  dec;

  // Segment code to {legal, nibble}; the decimal point must be dark (bit7 high).
  function automatic logic [4:0] decode(input logic [7:0] s);
    logic [4:0] r;
    case (s)
      8'h88:   r = {1'b1, 4'h0};
      8'hDB:   r = {1'b1, 4'h1};
      8'hA2:   r = {1'b1, 4'h2};
      8'h92:   r = {1'b1, 4'h3};
      8'hD1:   r = {1'b1, 4'h4};
      8'h94:   r = {1'b1, 4'h5};
      8'h84:   r = {1'b1, 4'h6};
      8'hDA:   r = {1'b1, 4'h7};
      8'h80:   r = {1'b1, 4'h8};
      8'h90:   r = {1'b1, 4'h9};
      8'hC0:   r = {1'b1, 4'hA};
      8'h85:   r = {1'b1, 4'hB};
      8'hAC:   r = {1'b1, 4'hC};
      8'h83:   r = {1'b1, 4'hD};
      8'hA4:   r = {1'b1, 4'hE};
      8'hE4:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Two-flop synchronizer for the asynchronous display lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_s1 <= 3'b000;
      dig_s2 <= 3'b000;
      seg_s1 <= 8'h00;
      seg_s2 <= 8'h00;
    end else begin
      dig_s1 <= dig;
      dig_s2 <= dig_s1;
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
    end
  end

  assign dig_onehot  = (dig_s2 == 3'b001) || (dig_s2 == 3'b010) || (dig_s2 == 3'b100);
  assign same_as_ref = (dig_s2 == ref_dig) && (seg_s2 == ref_seg);
  assign dec         = decode(seg_s2);

  // Capture decision: the current sample completes a full stable window.
  always_comb begin
    cap_now = 1'b0;
    case (state)
      IDLE:    cap_now = dig_onehot && (STB == 8'd1);
      SETTLE:  cap_now = same_as_ref && ((cnt + 8'd1) >= STB);
      default: cap_now = 1'b0;
    endcase
  end

  // Strobe tracking FSM: settle on a steady one-hot sample, then hold until it changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ref_dig <= 3'b000;
      ref_seg <= 8'h00;
      cnt     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (dig_onehot) begin
            ref_dig <= dig_s2;
            ref_seg <= seg_s2;
            cnt     <= 8'd1;
            state   <= cap_now ? HELD : SETTLE;
          end
        end
        SETTLE: begin
          if (!same_as_ref) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
            if (cap_now) state <= HELD;
          end
        end
        HELD: begin
          if (!same_as_ref) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-digit value, validity and staleness tracking; a capture overrides a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        num_r[i]   <= 4'h0;
        refresh[i] <= 24'd0;
      end
      valid <= 3'b000;
      upd   <= 1'b0;
      err   <= 1'b0;
    end else begin
      upd <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (cap_now && dig_s2[i] && dec[4]) begin
          num_r[i]   <= dec[3:0];
          valid[i]   <= 1'b1;
          refresh[i] <= 24'd0;
        end else begin
          if (refresh[i] != TO) refresh[i] <= refresh[i] + 24'd1;
          if (refresh[i] >= TO - 24'd1) valid[i] <= 1'b0;
          if (cap_now && dig_s2[i]) valid[i] <= 1'b0;
        end
      end
      if (cap_now) begin
        if (dec[4]) upd <= 1'b1;
        else        err <= 1'b1;
      end
    end
  end

  assign num0 = num_r[0];
  assign num1 = num_r[1];
  assign num2 = num_r[2];

endmodule

// File: tb/tb_seg_capture.sv
// tb/tb_seg_capture.sv - directed self-checking bench for seg_capture
module tb_seg_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dig;
  logic [7:0] seg;

  logic [3:0] num0, num1, num2;
  logic [2:0] valid;
  logic       upd, err;

  logic [3:0] q_num0, q_num1, q_num2;
  logic [2:0] q_valid;
  logic       q_upd, q_err;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int q_upd_cnt = 0;
  int base;
  int q_base;

  seg_capture #(.STABLE(4), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .dig(dig), .seg(seg),
    .num0(num0), .num1(num1), .num2(num2),
    .valid(valid), .upd(upd), .err(err)
  );

  seg_capture #(.STABLE(1), .TIMEOUT(100)) dut_q (
    .clk(clk), .rst(rst), .dig(dig), .seg(seg),
    .num0(q_num0), .num1(q_num1), .num2(q_num2),
    .valid(q_valid), .upd(q_upd), .err(q_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (upd === 1'b1)   upd_cnt++;
    if (q_upd === 1'b1) q_upd_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    dig = 3'b000;
    seg = 8'hFF;
    tick(2);
    check("reset_nums", {20'd0, num2, num1, num0}, 32'd0);
    check("reset_valid", {29'd0, valid}, 32'd0);
    check("reset_upd_err", {30'd0, upd, err}, 32'd0);
    rst = 1'b0;
    tick(3);

    // single strobe held 20 cycles
    base = upd_cnt;
    q_base = q_upd_cnt;
    dig = 3'b001; seg = 8'h94;
    tick(3);
    check("stable1_upd_edge3", {31'd0, q_upd}, 32'd1);
    check("upd_edge3", {31'd0, upd}, 32'd0);
    tick(2);
    check("upd_edge5", {31'd0, upd}, 32'd0);
    tick(1);
    check("upd_edge6", {31'd0, upd}, 32'd1);
    check("num0_5", {28'd0, num0}, 32'h5);
    check("valid_001", {29'd0, valid}, 32'b001);
    tick(1);
    check("upd_edge7", {31'd0, upd}, 32'd0);
    tick(13);
    check("one_upd_20cyc", upd_cnt - base, 32'd1);
    check("stable1_one_upd", q_upd_cnt - q_base, 32'd1);
    check("err_clear", {31'd0, err}, 32'd0);
    dig = 3'b000;
    tick(4);

    // refresh timeout
    dig = 3'b001; seg = 8'hDB;
    tick(6);
    check("to_capture_upd", {31'd0, upd}, 32'd1);
    check("to_num0_1", {28'd0, num0}, 32'h1);
    dig = 3'b000;
    tick(99);
    check("to_valid_at_99", {31'd0, valid[0]}, 32'd1);
    tick(1);
    check("to_valid_at_100", {31'd0, valid[0]}, 32'd0);
    check("to_num0_kept", {28'd0, num0}, 32'h1);

    // multiplexed scan, two rounds
    base = upd_cnt;
    for (int r = 0; r < 2; r++) begin
      dig = 3'b001; seg = 8'h83; tick(10);
      dig = 3'b010; seg = 8'hC0; tick(10);
      dig = 3'b100; seg = 8'hE4; tick(10);
    end
    check("scan_num0_d", {28'd0, num0}, 32'hD);
    check("scan_num1_a", {28'd0, num1}, 32'hA);
    check("scan_num2_f", {28'd0, num2}, 32'hF);
    check("scan_valid_111", {29'd0, valid}, 32'b111);
    check("scan_six_upd", upd_cnt - base, 32'd6);

    // short glitch rejected
    base = upd_cnt;
    dig = 3'b010; seg = 8'h80; tick(2);
    dig = 3'b000; tick(10);
    check("glitch_no_upd", upd_cnt - base, 32'd0);
    check("glitch_num1", {28'd0, num1}, 32'hA);
    check("glitch_valid", {29'd0, valid}, 32'b111);

    // illegal code
    base = upd_cnt;
    dig = 3'b100; seg = 8'hFF; tick(10);
    check("illegal_err", {31'd0, err}, 32'd1);
    check("illegal_valid2", {31'd0, valid[2]}, 32'd0);
    check("illegal_num2", {28'd0, num2}, 32'hF);
    check("illegal_no_upd", upd_cnt - base, 32'd0);
    dig = 3'b000; tick(3);
    dig = 3'b001; seg = 8'h88; tick(10);
    check("sticky_err", {31'd0, err}, 32'd1);
    check("post_err_num0", {28'd0, num0}, 32'h0);
    check("post_err_upd", upd_cnt - base, 32'd1);

    // reset in the middle of a settle window
    dig = 3'b000; tick(3);
    dig = 3'b001; seg = 8'h94; tick(4);
    rst = 1'b1;
    #1;
    check("async_rst_valid", {29'd0, valid}, 32'd0);
    check("async_rst_err", {31'd0, err}, 32'd0);
    check("async_rst_nums", {20'd0, num2, num1, num0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    check("rst_stable1_f2", {31'd0, q_upd}, 32'd0);
    tick(1);
    check("rst_stable1_f3", {31'd0, q_upd}, 32'd1);
    tick(2);
    check("rst_upd_f5", {31'd0, upd}, 32'd0);
    tick(1);
    check("rst_upd_f6", {31'd0, upd}, 32'd1);
    check("rst_num0_5", {28'd0, num0}, 32'h5);
    check("rst_valid_001", {29'd0, valid}, 32'b001);
    check("rst_err_0", {31'd0, err}, 32'd0);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
